reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Parametrised in-order commit buffer for the out-of-order core, sitting between the decoder/dispatch stage, the two result buses (ALU CDB and load/store CDB), the register file and the load/store queue. It generalises the first-generation ROB with configurable depth and width, explicit full/empty/count status, a valid/ready allocation handshake, CDB bypass on operand queries, and a whole-buffer flush on misprediction with a computed redirect PC.

## Interface
- DEPTH, 16, number of entries (power of two, 2..64); external tags 1..DEPTH, tag 0 = "none"
- TAG_W, 7, tag width; must satisfy 2^TAG_W > DEPTH
- XLEN, 32, data/address width
- REG_W, 5, architectural register index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_alloc_valid  in  1  dispatch requests an entry this cycle
- in_alloc_kind  in  2  0 = ALU (reg write), 1 = branch, 2 = store, 3 = JALR (reg write + redirect)
- in_alloc_dest  in  REG_W  destination register (ignored for kinds 1, 2)
- in_alloc_pc  in  XLEN  instruction PC
- in_alloc_pred_taken  in  1  predictor decision (kind 1 only)
- out_alloc_ready  out  1  = !full
- out_alloc_tag  out  TAG_W  tag granted if allocation fires this cycle; 0 when full
- in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target  in  TAG_W/XLEN/1/XLEN  ALU result bus
- in_ls_tag, in_ls_value  in  TAG_W/XLEN  load/store result bus
- in_query_tag1, in_query_tag2  in  TAG_W  operand lookups from decoder
- out_query_ready1/2, out_query_value1/2  out  1/XLEN  lookup results
- out_reg_we, out_reg_idx, out_reg_tag, out_reg_value  out  1/REG_W/TAG_W/XLEN  register commit
- out_store_commit_valid, out_store_commit_tag  out  1/TAG_W  store release to LSQ
- out_flush, out_redirect_pc  out  1/XLEN  misprediction flush and fetch redirect
- out_full, out_empty, out_count  out  1/1/TAG_W  occupancy status

## Operation
- Circular buffer: head, tail (index 0..DEPTH-1) plus count 0..DEPTH; tag = index+1. full = (count==DEPTH), empty = (count==0).
- Allocation fires when in_alloc_valid && out_alloc_ready: entry at tail written (ready=0, kind, dest, pc, pred), tail wraps DEPTH-1 -> 0. out_alloc_ready uses current count only; a same-cycle commit does not free a slot for that cycle.
- CDB write: nonzero tag sets entry value, ready=1; ALU bus also stores taken/target. Both buses may write in one cycle (distinct tags guaranteed); writes to tags of free entries are ignored.
- Query: tag 0 -> ready=0, value=0. Else ready/value from entry; if in_cdb_tag or in_ls_tag matches this cycle, returns bus value with ready=1 (bypass, LS bus lower priority).
- Commit: at most one per cycle when !empty and head entry ready; head advances, count decrements.
  - kind 0: reg_we=1, idx/tag/value from entry.
  - kind 1: no reg write; mispredict if taken != pred_taken -> flush, redirect = taken ? target : pc+4.
  - kind 2: store_commit_valid=1, tag = head tag.
  - kind 3: reg write of value (link) and always flush, redirect = target.
- Flush: same edge as the flushing commit, head=tail=count=0, all ready bits cleared; allocation and CDB writes in that cycle are discarded.
- count updates: +1 on alloc, -1 on commit, unchanged if both.

## Timing
- Reset (async): head=tail=count=0, all ready bits 0, every registered output 0; out_empty=1, out_alloc_ready=1, out_alloc_tag=1.
- Commit outputs are registered single-cycle pulses asserted the cycle after the commit edge; deasserted (all zero) otherwise.
- Minimum lifetime: alloc at edge N, CDB at edge N+1, commit edge N+2, outputs visible during N+2..N+3.
- Query, out_alloc_*, full/empty/count are combinational from state (query also from CDB inputs).
- Reset mid-operation discards all entries immediately; no pending pulse survives.

## Test plan
- Reset -> out_empty=1, out_count=0, out_alloc_tag=1, all commit/flush outputs 0.
- DEPTH=4: allocate 4 ALU ops (dest x1..x4) -> tags 1..4, out_full=1, out_alloc_tag=0; CDB completes tag 3 first, then 1,2,4 -> commits strictly in order x1..x4, one per cycle.
- Wrap: after 4 commits allocate 3 more -> tags 1,2,3 reused; simultaneous alloc+commit at count=2 keeps count=2.
- Branch pc=0x100, pred=0, CDB taken=1 target=0x200 -> out_flush=1, redirect=0x200, count=0 next cycle; younger tag with same-cycle CDB write never commits.
- Branch pred=1, CDB taken=0, pc=0x40 -> redirect=0x44; correct prediction -> no flush.
- Query tag2 while in_cdb_tag=2 value=0xDEAD -> ready=1, value=0xDEAD same cycle; query tag 0 -> ready=0, value=0; store commit -> store_commit_valid pulse with its tag, reg_we=0.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch, result-bus, query, commit and status signals of the reorder buffer.
interface reorder_buffer_if #(
  parameter int TAG_W = 7,
  parameter int XLEN  = 32,
  parameter int REG_W = 5
);
  logic             in_alloc_valid;
  logic [1:0]       in_alloc_kind;
  logic [REG_W-1:0] in_alloc_dest;
  logic [XLEN-1:0]  in_alloc_pc;
  logic             in_alloc_pred_taken;
  logic             out_alloc_ready;
  logic [TAG_W-1:0] out_alloc_tag;
  logic [TAG_W-1:0] in_cdb_tag;
  logic [XLEN-1:0]  in_cdb_value;
  logic             in_cdb_taken;
  logic [XLEN-1:0]  in_cdb_target;
  logic [TAG_W-1:0] in_ls_tag;
  logic [XLEN-1:0]  in_ls_value;
  logic [TAG_W-1:0] in_query_tag1;
  logic [TAG_W-1:0] in_query_tag2;
  logic             out_query_ready1;
  logic             out_query_ready2;
  logic [XLEN-1:0]  out_query_value1;
  logic [XLEN-1:0]  out_query_value2;
  logic             out_reg_we;
  logic [REG_W-1:0] out_reg_idx;
  logic [TAG_W-1:0] out_reg_tag;
  logic [XLEN-1:0]  out_reg_value;
  logic             out_store_commit_valid;
  logic [TAG_W-1:0] out_store_commit_tag;
  logic             out_flush;
  logic [XLEN-1:0]  out_redirect_pc;
  logic             out_full;
  logic             out_empty;
  logic [TAG_W-1:0] out_count;
  modport slave (
    input  in_alloc_valid, in_alloc_kind, in_alloc_dest, in_alloc_pc, in_alloc_pred_taken,
    input  in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target, in_ls_tag, in_ls_value,
    input  in_query_tag1, in_query_tag2,
    output out_alloc_ready, out_alloc_tag, out_query_ready1, out_query_ready2,
    output out_query_value1, out_query_value2, out_reg_we, out_reg_idx, out_reg_tag, out_reg_value,
    output out_store_commit_valid, out_store_commit_tag, out_flush, out_redirect_pc,
    output out_full, out_empty, out_count
  );
  modport master (
    output in_alloc_valid, in_alloc_kind, in_alloc_dest, in_alloc_pc, in_alloc_pred_taken,
    output in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target, in_ls_tag, in_ls_value,
    output in_query_tag1, in_query_tag2,
    input  out_alloc_ready, out_alloc_tag, out_query_ready1, out_query_ready2,
    input  out_query_value1, out_query_value2, out_reg_we, out_reg_idx, out_reg_tag, out_reg_value,
    input  out_store_commit_valid, out_store_commit_tag, out_flush, out_redirect_pc,
    input  out_full, out_empty, out_count
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order commit buffer with dual result buses, operand bypass
// and whole-buffer flush on branch mispredict or JALR.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 7,
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input logic clk,
  input logic rst,
  reorder_buffer_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] DEPTH_T = TAG_W'(DEPTH);
  typedef enum logic [1:0] {K_ALU, K_BR, K_ST, K_JALR} kind_e;
  logic [DEPTH-1:0] r_ready;
  logic [DEPTH-1:0] r_pred;
  logic [DEPTH-1:0] r_taken;
  kind_e            r_kind   [DEPTH];
  logic [REG_W-1:0] r_dest   [DEPTH];
  logic [XLEN-1:0]  r_pc     [DEPTH];
  logic [XLEN-1:0]  r_value  [DEPTH];
  logic [XLEN-1:0]  r_target [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [TAG_W-1:0] r_count;
  logic             r_reg_we;
  logic [REG_W-1:0] r_reg_idx;
  logic [TAG_W-1:0] r_reg_tag;
  logic [XLEN-1:0]  r_reg_value;
  logic             r_st_valid;
  logic [TAG_W-1:0] r_st_tag;
  logic             r_flush;
  logic [XLEN-1:0]  r_redirect;
  logic [DEPTH-1:0] w_occ;
  logic [IDX_W-1:0] w_off;
  logic             w_full;
  logic             w_alloc;
  logic             w_commit;
  logic             w_reg_we;
  logic             w_st;
  logic             w_flush;
  logic [XLEN-1:0]  w_redirect;
  kind_e            w_h_kind;
  logic [TAG_W-1:0] w_head_tag;
  logic [IDX_W-1:0] w_cdb_idx;
  logic [IDX_W-1:0] w_ls_idx;
  logic [IDX_W-1:0] w_q1_idx;
  logic [IDX_W-1:0] w_q2_idx;
  logic             w_cdb_hit;
  logic             w_ls_hit;

  function automatic logic [IDX_W-1:0] f_idx(input logic [TAG_W-1:0] t);
    logic [TAG_W-1:0] m;
    m = t - TAG_W'(1);
    return m[IDX_W-1:0];
  endfunction

  function automatic logic f_in_range(input logic [TAG_W-1:0] t);
    return (t != '0) && (t <= DEPTH_T);
  endfunction

  // An entry is live when its distance from head is below the occupancy count.
  always_comb begin
    w_off = '0;
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off    = IDX_W'(i) - r_head;
      w_occ[i] = TAG_W'(w_off) < r_count;
    end
  end

  assign w_full     = r_count == DEPTH_T;
  assign w_alloc    = bus.in_alloc_valid && !w_full;
  assign w_cdb_idx  = f_idx(bus.in_cdb_tag);
  assign w_ls_idx   = f_idx(bus.in_ls_tag);
  assign w_cdb_hit  = f_in_range(bus.in_cdb_tag) && w_occ[w_cdb_idx];
  assign w_ls_hit   = f_in_range(bus.in_ls_tag) && w_occ[w_ls_idx];
  assign w_h_kind   = r_kind[r_head];
  assign w_head_tag = TAG_W'(r_head) + TAG_W'(1);
  assign w_commit   = (r_count != '0) && r_ready[r_head];
  assign w_reg_we   = w_commit && (w_h_kind == K_ALU || w_h_kind == K_JALR);
  assign w_st       = w_commit && (w_h_kind == K_ST);
  assign w_flush    = w_commit && (w_h_kind == K_JALR ||
                      (w_h_kind == K_BR && r_taken[r_head] != r_pred[r_head]));
  assign w_redirect = (w_h_kind == K_JALR || r_taken[r_head]) ? r_target[r_head]
                                                              : r_pc[r_head] + XLEN'(4);

  assign bus.out_alloc_ready = !w_full;
  assign bus.out_alloc_tag   = w_full ? '0 : TAG_W'(r_tail) + TAG_W'(1);
  assign bus.out_full        = w_full;
  assign bus.out_empty       = r_count == '0;
  assign bus.out_count       = r_count;

  // Result buses bypass the stored entry so dispatch sees a value in its completion cycle.
  assign w_q1_idx = f_idx(bus.in_query_tag1);
  assign w_q2_idx = f_idx(bus.in_query_tag2);
  assign bus.out_query_ready1 = (bus.in_query_tag1 == '0) ? 1'b0 :
                                (bus.in_query_tag1 == bus.in_cdb_tag || bus.in_query_tag1 == bus.in_ls_tag) ? 1'b1 :
                                f_in_range(bus.in_query_tag1) && r_ready[w_q1_idx];
  assign bus.out_query_value1 = (bus.in_query_tag1 == '0) ? '0 :
                                (bus.in_query_tag1 == bus.in_cdb_tag) ? bus.in_cdb_value :
                                (bus.in_query_tag1 == bus.in_ls_tag) ? bus.in_ls_value :
                                f_in_range(bus.in_query_tag1) ? r_value[w_q1_idx] : '0;
  assign bus.out_query_ready2 = (bus.in_query_tag2 == '0) ? 1'b0 :
                                (bus.in_query_tag2 == bus.in_cdb_tag || bus.in_query_tag2 == bus.in_ls_tag) ? 1'b1 :
                                f_in_range(bus.in_query_tag2) && r_ready[w_q2_idx];
  assign bus.out_query_value2 = (bus.in_query_tag2 == '0) ? '0 :
                                (bus.in_query_tag2 == bus.in_cdb_tag) ? bus.in_cdb_value :
                                (bus.in_query_tag2 == bus.in_ls_tag) ? bus.in_ls_value :
                                f_in_range(bus.in_query_tag2) ? r_value[w_q2_idx] : '0;

  assign bus.out_reg_we             = r_reg_we;
  assign bus.out_reg_idx            = r_reg_idx;
  assign bus.out_reg_tag            = r_reg_tag;
  assign bus.out_reg_value          = r_reg_value;
  assign bus.out_store_commit_valid = r_st_valid;
  assign bus.out_store_commit_tag   = r_st_tag;
  assign bus.out_flush              = r_flush;
  assign bus.out_redirect_pc        = r_redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_ready     <= '0;
      r_reg_we    <= 1'b0;
      r_reg_idx   <= '0;
      r_reg_tag   <= '0;
      r_reg_value <= '0;
      r_st_valid  <= 1'b0;
      r_st_tag    <= '0;
      r_flush     <= 1'b0;
      r_redirect  <= '0;
    end else begin
      r_reg_we    <= w_reg_we;
      r_reg_idx   <= w_reg_we ? r_dest[r_head] : '0;
      r_reg_tag   <= w_reg_we ? w_head_tag : '0;
      r_reg_value <= w_reg_we ? r_value[r_head] : '0;
      r_st_valid  <= w_st;
      r_st_tag    <= w_st ? w_head_tag : '0;
      r_flush     <= w_flush;
      r_redirect  <= w_flush ? w_redirect : '0;
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_ready <= '0;
      end else begin
        r_head  <= w_commit ? r_head + 1'b1 : r_head;
        r_tail  <= w_alloc ? r_tail + 1'b1 : r_tail;
        r_count <= r_count + TAG_W'(w_alloc) - TAG_W'(w_commit);
        if (w_alloc) r_ready[r_tail] <= 1'b0;
        if (w_cdb_hit) r_ready[w_cdb_idx] <= 1'b1;
        if (w_ls_hit) r_ready[w_ls_idx] <= 1'b1;
      end
    end
  end

  // Payload needs no reset: ready bits and occupancy gate every use of it.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_kind[r_tail] <= kind_e'(bus.in_alloc_kind);
      r_dest[r_tail] <= bus.in_alloc_dest;
      r_pc[r_tail]   <= bus.in_alloc_pc;
      r_pred[r_tail] <= bus.in_alloc_pred_taken;
    end
    if (w_cdb_hit) begin
      r_value[w_cdb_idx]  <= bus.in_cdb_value;
      r_taken[w_cdb_idx]  <= bus.in_cdb_taken;
      r_target[w_cdb_idx] <= bus.in_cdb_target;
    end
    if (w_ls_hit) r_value[w_ls_idx] <= bus.in_ls_value;
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench for a 4-entry reorder buffer; expected commit pulses
// are queued in program order at dispatch and matched against the registered commit outputs.
module tb_reorder_buffer;
  logic clk;
  logic rst;
  int n_vec;
  int n_err;

  typedef struct packed {
    logic        we;
    logic [4:0]  idx;
    logic [6:0]  tag;
    logic [31:0] val;
    logic        sv;
    logic [6:0]  stag;
    logic        fl;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];

  reorder_buffer_if #(.TAG_W(7), .XLEN(32), .REG_W(5)) bus();
  reorder_buffer #(.DEPTH(4), .TAG_W(7), .XLEN(32), .REG_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t e_reg(input logic [4:0] idx, input logic [6:0] tag, input logic [31:0] val);
    return '{we: 1'b1, idx: idx, tag: tag, val: val, sv: 1'b0, stag: '0, fl: 1'b0, rd: '0};
  endfunction

  function automatic exp_t e_flush(input logic [31:0] rd);
    return '{we: 1'b0, idx: '0, tag: '0, val: '0, sv: 1'b0, stag: '0, fl: 1'b1, rd: rd};
  endfunction

  function automatic exp_t e_store(input logic [6:0] tag);
    return '{we: 1'b0, idx: '0, tag: '0, val: '0, sv: 1'b1, stag: tag, fl: 1'b0, rd: '0};
  endfunction

  function automatic exp_t e_jalr(input logic [4:0] idx, input logic [6:0] tag,
                                  input logic [31:0] val, input logic [31:0] rd);
    return '{we: 1'b1, idx: idx, tag: tag, val: val, sv: 1'b0, stag: '0, fl: 1'b1, rd: rd};
  endfunction

  always @(negedge clk) begin
    if (!rst && (bus.out_reg_we || bus.out_store_commit_valid || bus.out_flush)) begin
      if (q.size() == 0) begin
        check("spurious_commit", 64'(bus.out_reg_tag), 64'h0);
        check("spurious_flush", 64'(bus.out_flush), 64'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("reg_we", 64'(bus.out_reg_we), 64'(e.we));
        check("reg_idx", 64'(bus.out_reg_idx), 64'(e.idx));
        check("reg_tag", 64'(bus.out_reg_tag), 64'(e.tag));
        check("reg_value", 64'(bus.out_reg_value), 64'(e.val));
        check("st_valid", 64'(bus.out_store_commit_valid), 64'(e.sv));
        check("st_tag", 64'(bus.out_store_commit_tag), 64'(e.stag));
        check("flush", 64'(bus.out_flush), 64'(e.fl));
        check("redirect", 64'(bus.out_redirect_pc), 64'(e.rd));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.in_alloc_valid = 1'b0;
    bus.in_cdb_tag     = '0;
    bus.in_ls_tag      = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic alloc(input logic [1:0] kind, input logic [4:0] dest, input logic [31:0] pc, input logic pred);
    bus.in_alloc_valid      = 1'b1;
    bus.in_alloc_kind       = kind;
    bus.in_alloc_dest       = dest;
    bus.in_alloc_pc         = pc;
    bus.in_alloc_pred_taken = pred;
    step();
  endtask

  task automatic cdb(input logic [6:0] tag, input logic [31:0] val, input logic taken, input logic [31:0] tgt);
    bus.in_cdb_tag    = tag;
    bus.in_cdb_value  = val;
    bus.in_cdb_taken  = taken;
    bus.in_cdb_target = tgt;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    bus.in_alloc_valid = 1'b0;
    bus.in_alloc_kind = '0;
    bus.in_alloc_dest = '0;
    bus.in_alloc_pc = '0;
    bus.in_alloc_pred_taken = 1'b0;
    bus.in_cdb_tag = '0;
    bus.in_cdb_value = '0;
    bus.in_cdb_taken = 1'b0;
    bus.in_cdb_target = '0;
    bus.in_ls_tag = '0;
    bus.in_ls_value = '0;
    bus.in_query_tag1 = '0;
    bus.in_query_tag2 = '0;
    #2 rst = 1'b1;
    #2;
    check("rst_empty", 64'(bus.out_empty), 64'h1);
    check("rst_count", 64'(bus.out_count), 64'h0);
    check("rst_alloc_tag", 64'(bus.out_alloc_tag), 64'h1);
    check("rst_alloc_ready", 64'(bus.out_alloc_ready), 64'h1);
    check("rst_outs", 64'({bus.out_reg_we, bus.out_store_commit_valid, bus.out_flush}), 64'h0);
    check("rst_redirect", 64'(bus.out_redirect_pc), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 1; k <= 4; k++) begin
      check("fill_tag", 64'(bus.out_alloc_tag), 64'(k));
      q.push_back(e_reg(5'(k), 7'(k), 32'h1000 + 32'(k)));
      alloc(2'd0, 5'(k), 32'h10 * 32'(k), 1'b0);
    end
    check("full", 64'(bus.out_full), 64'h1);
    check("full_tag", 64'(bus.out_alloc_tag), 64'h0);
    check("full_ready", 64'(bus.out_alloc_ready), 64'h0);
    check("full_count", 64'(bus.out_count), 64'h4);
    bus.in_alloc_valid = 1'b1;
    step();
    check("full_noalloc", 64'(bus.out_count), 64'h4);
    cdb(7'd3, 32'h1003, 1'b0, '0);
    cdb(7'd1, 32'h1001, 1'b0, '0);
    cdb(7'd2, 32'h1002, 1'b0, '0);
    cdb(7'd4, 32'h1004, 1'b0, '0);
    idle(4);
    check("drain1_count", 64'(bus.out_count), 64'h0);
    check("drain1_empty", 64'(bus.out_empty), 64'h1);

    check("wrap_tag1", 64'(bus.out_alloc_tag), 64'h1);
    q.push_back(e_reg(5'd5, 7'd1, 32'h2001));
    alloc(2'd0, 5'd5, 32'h200, 1'b0);
    q.push_back(e_reg(5'd6, 7'd2, 32'h2002));
    alloc(2'd0, 5'd6, 32'h204, 1'b0);
    check("wrap_count2", 64'(bus.out_count), 64'h2);
    cdb(7'd1, 32'h2001, 1'b0, '0);
    check("wrap_tag3", 64'(bus.out_alloc_tag), 64'h3);
    q.push_back(e_reg(5'd7, 7'd3, 32'h2003));
    alloc(2'd0, 5'd7, 32'h208, 1'b0);
    check("alloc_commit_count", 64'(bus.out_count), 64'h2);
    cdb(7'd2, 32'h2002, 1'b0, '0);
    cdb(7'd3, 32'h2003, 1'b0, '0);
    idle(3);
    check("drain2_count", 64'(bus.out_count), 64'h0);

    check("br_tag", 64'(bus.out_alloc_tag), 64'h4);
    q.push_back(e_flush(32'h200));
    alloc(2'd1, 5'd0, 32'h100, 1'b0);
    alloc(2'd0, 5'd8, 32'h104, 1'b0);
    cdb(7'd4, 32'h0, 1'b1, 32'h200);
    bus.in_ls_tag      = 7'd1;
    bus.in_ls_value    = 32'h77;
    bus.in_alloc_valid = 1'b1;
    bus.in_alloc_dest  = 5'd9;
    bus.in_alloc_kind  = 2'd0;
    step();
    check("flush_count", 64'(bus.out_count), 64'h0);
    check("flush_empty", 64'(bus.out_empty), 64'h1);
    check("flush_tag", 64'(bus.out_alloc_tag), 64'h1);
    idle(4);

    q.push_back(e_flush(32'h44));
    alloc(2'd1, 5'd0, 32'h40, 1'b1);
    cdb(7'd1, 32'h0, 1'b0, 32'h999);
    idle(3);
    alloc(2'd1, 5'd0, 32'h80, 1'b1);
    cdb(7'd1, 32'h0, 1'b1, 32'h300);
    step();
    check("okbr_flush", 64'(bus.out_flush), 64'h0);
    check("okbr_we", 64'(bus.out_reg_we), 64'h0);
    check("okbr_count", 64'(bus.out_count), 64'h0);

    check("q_alloc_tag", 64'(bus.out_alloc_tag), 64'h2);
    q.push_back(e_reg(5'd10, 7'd2, 32'hDEAD));
    alloc(2'd0, 5'd10, 32'h600, 1'b0);
    bus.in_query_tag1 = 7'd2;
    bus.in_query_tag2 = 7'd0;
    #1;
    check("q_pre_ready", 64'(bus.out_query_ready1), 64'h0);
    bus.in_cdb_tag   = 7'd2;
    bus.in_cdb_value = 32'hDEAD;
    bus.in_cdb_taken = 1'b0;
    #1;
    check("q_byp_ready", 64'(bus.out_query_ready1), 64'h1);
    check("q_byp_value", 64'(bus.out_query_value1), 64'hDEAD);
    check("q0_ready", 64'(bus.out_query_ready2), 64'h0);
    check("q0_value", 64'(bus.out_query_value2), 64'h0);
    step();
    check("q_stored_ready", 64'(bus.out_query_ready1), 64'h1);
    check("q_stored_value", 64'(bus.out_query_value1), 64'hDEAD);
    q.push_back(e_store(7'd3));
    alloc(2'd2, 5'd0, 32'h700, 1'b0);
    bus.in_ls_tag     = 7'd3;
    bus.in_ls_value   = 32'h55;
    bus.in_query_tag1 = 7'd3;
    #1;
    check("q_ls_ready", 64'(bus.out_query_ready1), 64'h1);
    check("q_ls_value", 64'(bus.out_query_value1), 64'h55);
    step();
    bus.in_query_tag1 = '0;
    idle(3);

    check("jalr_tag", 64'(bus.out_alloc_tag), 64'h4);
    q.push_back(e_jalr(5'd1, 7'd4, 32'h504, 32'h800));
    alloc(2'd3, 5'd1, 32'h500, 1'b0);
    alloc(2'd0, 5'd12, 32'h504, 1'b0);
    cdb(7'd1, 32'h99, 1'b0, '0);
    cdb(7'd4, 32'h504, 1'b0, 32'h800);
    idle(4);
    check("jalr_count", 64'(bus.out_count), 64'h0);

    alloc(2'd0, 5'd3, 32'h900, 1'b0);
    cdb(7'd1, 32'h42, 1'b0, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_we", 64'(bus.out_reg_we), 64'h0);
    check("mid_rst_count", 64'(bus.out_count), 64'h0);
    check("mid_rst_empty", 64'(bus.out_empty), 64'h1);
    check("mid_rst_tag", 64'(bus.out_alloc_tag), 64'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    check("drain_queue", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
